// File: rtl/llki_pkg.sv
// Shared LLKI definitions used by both ends of the discrete key-load channel.
package llki_pkg;

    localparam int LLKI_WORD_W = 64;

    typedef enum logic [1:0] {
        LLKI_OP_LOAD   = 2'd0,
        LLKI_OP_CLEAR  = 2'd1,
        LLKI_OP_STATUS = 2'd2
    } llki_op_e;

    typedef enum logic [2:0] {
        LLKI_ST_OK          = 3'd0,
        LLKI_ST_KEY_PRESENT = 3'd1,
        LLKI_ST_BAD_LEN     = 3'd2,
        LLKI_ST_BAD_OP      = 3'd3,
        LLKI_ST_TIMEOUT     = 3'd4
    } llki_status_e;

    typedef enum logic [1:0] {
        MST_IDLE      = 2'd0,
        MST_SEND      = 2'd1,
        MST_WAIT_RESP = 2'd2,
        MST_DONE      = 2'd3
    } llki_mst_state_e;

    // Opcode 3 has no meaning on the channel and is rejected locally.
    function automatic logic llki_op_known(input logic [1:0] op);
        return (op != 2'd3);
    endfunction

endpackage

// File: rtl/llki_timeout_ctr.sv
// Progress watchdog for llki_discrete_master. Only instantiated when
// LLKI_MASTER_TIMEOUT_EN is defined.
module llki_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // Down-counter: reload on progress, count down on idle cycles, park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/llki_discrete_master.sv
// LLKI discrete-channel initiator: serialises one key command into request
// beats, waits for the slave's status and returns a single completion pulse.
// Optional slave watchdog enabled by defining LLKI_MASTER_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | cmd_ready high, waiting for a command
// SEND      | driving request beats, one key word per beat
// WAIT_RESP | all beats accepted, waiting for the slave's status
// DONE      | one-cycle done_valid with the latched status
module llki_discrete_master
    import llki_pkg::*;
#(
    parameter int KEY_WORDS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [LLKI_WORD_W*KEY_WORDS-1:0] cmd_key,
    output logic                            done_valid,
    output logic [2:0]                      done_status,
    output logic                            llki_req_valid,
    input  logic                            llki_req_ready,
    output logic [1:0]                      llki_req_op,
    output logic [LLKI_WORD_W-1:0]          llki_req_data,
    output logic                            llki_req_last,
    input  logic                            llki_resp_valid,
    input  logic [2:0]                      llki_resp_status
);

    localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int KEY_W = LLKI_WORD_W * KEY_WORDS;

    llki_mst_state_e        state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   done_valid_q, done_valid_d;
    logic [2:0]             done_status_q, done_status_d;
    logic                   req_valid_q, req_valid_d;
    logic [1:0]             req_op_q, req_op_d;
    logic [LLKI_WORD_W-1:0] req_data_q, req_data_d;
    logic                   req_last_q, req_last_d;

    logic                   finish;
    logic [2:0]             finish_st;
    logic                   to_expired;

`ifdef LLKI_MASTER_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W    = (TO_BITS > 8) ? TO_BITS : 8;

    logic to_load;
    logic to_tick;

    // Progress = command accepted into SEND, or any accepted beat (which
    // also covers the step into WAIT_RESP).
    assign to_load = ((state_q == MST_IDLE) && cmd_valid && llki_op_known(cmd_op)) ||
                     ((state_q == MST_SEND) && llki_req_ready);
    assign to_tick = ((state_q == MST_SEND) && !llki_req_ready) ||
                     ((state_q == MST_WAIT_RESP) && !llki_resp_valid);

    llki_timeout_ctr #(
        .W (TO_W)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (to_load),
        .load_val_i (TO_W'(TIMEOUT_CYCLES)),
        .tick_i     (to_tick),
        .expired_o  (to_expired)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign to_expired         = 1'b0;
`endif

    // Next-state, key shifting and registered-output next values.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        key_d         = key_q;
        done_valid_d  = 1'b0;
        done_status_d = '0;
        req_valid_d   = req_valid_q;
        req_op_d      = req_op_q;
        req_data_d    = req_data_q;
        req_last_d    = req_last_q;
        finish        = 1'b0;
        finish_st     = LLKI_ST_OK;

        case (state_q)
            MST_IDLE: begin
                if (cmd_valid) begin
                    if (!llki_op_known(cmd_op)) begin
                        finish    = 1'b1;
                        finish_st = LLKI_ST_BAD_OP;
                    end else begin
                        state_d     = MST_SEND;
                        idx_d       = '0;
                        req_valid_d = 1'b1;
                        req_op_d    = cmd_op;
                        if (cmd_op == LLKI_OP_LOAD) begin
                            req_data_d = cmd_key[LLKI_WORD_W-1:0];
                            key_d      = cmd_key >> LLKI_WORD_W;
                            req_last_d = (KEY_WORDS == 1);
                        end else begin
                            req_data_d = '0;
                            key_d      = '0;
                            req_last_d = 1'b1;
                        end
                    end
                end
            end

            MST_SEND: begin
                // A response mid-send is the slave rejecting the command early.
                if (llki_resp_valid) begin
                    finish    = 1'b1;
                    finish_st = llki_resp_status;
                end else if (to_expired) begin
                    finish    = 1'b1;
                    finish_st = LLKI_ST_TIMEOUT;
                end else if (llki_req_ready) begin
                    if (req_last_q) begin
                        state_d     = MST_WAIT_RESP;
                        req_valid_d = 1'b0;
                        req_op_d    = '0;
                        req_data_d  = '0;
                        req_last_d  = 1'b0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        req_data_d = key_q[LLKI_WORD_W-1:0];
                        key_d      = key_q >> LLKI_WORD_W;
                        req_last_d = ((int'(idx_q) + 1) == (KEY_WORDS - 1));
                    end
                end
            end

            MST_WAIT_RESP: begin
                if (llki_resp_valid) begin
                    finish    = 1'b1;
                    finish_st = llki_resp_status;
                end else if (to_expired) begin
                    finish    = 1'b1;
                    finish_st = LLKI_ST_TIMEOUT;
                end
            end

            MST_DONE: begin
                state_d = MST_IDLE;
            end

            default: begin
                state_d = MST_IDLE;
            end
        endcase

        // Every path into DONE scrubs key material and quiets the channel.
        if (finish) begin
            state_d       = MST_DONE;
            done_valid_d  = 1'b1;
            done_status_d = finish_st;
            key_d         = '0;
            idx_d         = '0;
            req_valid_d   = 1'b0;
            req_op_d      = '0;
            req_data_d    = '0;
            req_last_d    = 1'b0;
        end

        cmd_ready_d = (state_d == MST_IDLE);
    end

    // State and output registers; reset also scrubs the key register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= MST_IDLE;
            idx_q         <= '0;
            key_q         <= '0;
            cmd_ready_q   <= 1'b1;
            done_valid_q  <= 1'b0;
            done_status_q <= '0;
            req_valid_q   <= 1'b0;
            req_op_q      <= '0;
            req_data_q    <= '0;
            req_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            key_q         <= key_d;
            cmd_ready_q   <= cmd_ready_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            req_valid_q   <= req_valid_d;
            req_op_q      <= req_op_d;
            req_data_q    <= req_data_d;
            req_last_q    <= req_last_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign done_valid     = done_valid_q;
    assign done_status    = done_status_q;
    assign llki_req_valid = req_valid_q;
    assign llki_req_op    = req_op_q;
    assign llki_req_data  = req_data_q;
    assign llki_req_last  = req_last_q;

endmodule

// File: tb/tb_llki_discrete_master.sv
// Scoreboard bench for llki_discrete_master with a scripted slave model.
module tb_llki_discrete_master;
    import llki_pkg::*;

    localparam int KW = 2;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [127:0]  cmd_key;
    logic          done_valid;
    logic [2:0]    done_status;
    logic          llki_req_valid;
    logic          llki_req_ready;
    logic [1:0]    llki_req_op;
    logic [63:0]   llki_req_data;
    logic          llki_req_last;
    logic          llki_resp_valid;
    logic [2:0]    llki_resp_status;

    always #5 clk = ~clk;

    llki_discrete_master #(
        .KEY_WORDS      (KW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_key          (cmd_key),
        .done_valid       (done_valid),
        .done_status      (done_status),
        .llki_req_valid   (llki_req_valid),
        .llki_req_ready   (llki_req_ready),
        .llki_req_op      (llki_req_op),
        .llki_req_data    (llki_req_data),
        .llki_req_last    (llki_req_last),
        .llki_resp_valid  (llki_resp_valid),
        .llki_resp_status (llki_resp_status)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard queues: beats are {op, last, data}
    logic [66:0] beat_q[$];
    logic [2:0]  done_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave script: 0 = respond the cycle after last, 1 = never, 2 = reject during beat 0
    int       resp_mode    = 0;
    logic [2:0] resp_st    = 3'd0;
    int       stall_beat   = -1;
    int       stall_left   = 0;
    int       beat_no      = 0;
    bit       early_fired  = 1'b0;
    bit       resp_pending = 1'b0;

    int       hs_count     = 0;
    int       done_count   = 0;
    int       extra_beats  = 0;
    int       extra_done   = 0;
    int       acc_cyc      = 0;
    int       done_cyc     = 0;

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [66:0] prev_beat  = '0;

    // monitor: sample between edges, pop expectations as the DUT produces them
    initial begin
        logic [66:0] eb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (llki_req_valid && llki_req_ready) begin
                    hs_count++;
                    beat_no++;
                    if (beat_q.size() > 0) begin
                        eb = beat_q.pop_front();
                        check("beat_op",   80'(llki_req_op),   80'(eb[66:65]));
                        check("beat_last", 80'(llki_req_last), 80'(eb[64]));
                        check("beat_data", 80'(llki_req_data), 80'(eb[63:0]));
                    end else begin
                        extra_beats++;
                    end
                    if (llki_req_last && resp_mode == 0) resp_pending = 1'b1;
                end
                if (prev_valid && !prev_ready && llki_req_valid)
                    check("hold", 80'({llki_req_op, llki_req_last, llki_req_data}), 80'(prev_beat));
                prev_valid = llki_req_valid;
                prev_ready = llki_req_ready;
                prev_beat  = {llki_req_op, llki_req_last, llki_req_data};
                if (done_valid) begin
                    done_count++;
                    done_cyc = cyc;
                    if (done_q.size() > 0) check("done_status", 80'(done_status), 80'(done_q.pop_front()));
                    else extra_done++;
                end
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
            end
        end
    end

    // slave driver
    initial begin
        llki_req_ready   = 1'b1;
        llki_resp_valid  = 1'b0;
        llki_resp_status = 3'd0;
        forever begin
            @(posedge clk);
            #1;
            llki_resp_valid = 1'b0;
            llki_req_ready  = 1'b1;
            if (resp_pending) begin
                llki_resp_valid  = 1'b1;
                llki_resp_status = resp_st;
                resp_pending     = 1'b0;
            end
            if (llki_req_valid) begin
                if (resp_mode == 2 && !early_fired) begin
                    llki_req_ready   = 1'b0;
                    llki_resp_valid  = 1'b1;
                    llki_resp_status = resp_st;
                    early_fired      = 1'b1;
                end else if (beat_no == stall_beat && stall_left > 0) begin
                    llki_req_ready = 1'b0;
                    stall_left--;
                end
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [127:0] key);
        bit accepted = 1'b0;
        @(posedge clk);
        #1;
        beat_no     = 0;
        early_fired = 1'b0;
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_key     = key;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) accepted = 1'b1;
        end
        check("cmd_accept", 80'(accepted), 80'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_key   = '0;
    endtask

    task automatic wait_done(input int bound);
        int  n   = done_count;
        bit  got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            #2;
            if (done_count != n) got = 1'b1;
        end
        check("done_seen", 80'(got), 80'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] k;
        int           hs0;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_key   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready",   80'(cmd_ready),      80'(1));
        check("rst_req_valid",   80'(llki_req_valid), 80'(0));
        check("rst_req_op",      80'(llki_req_op),    80'(0));
        check("rst_req_data",    80'(llki_req_data),  80'(0));
        check("rst_req_last",    80'(llki_req_last),  80'(0));
        check("rst_done_valid",  80'(done_valid),     80'(0));
        check("rst_done_status", 80'(done_status),    80'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // LOAD, always-ready slave, OK response
        k = 128'h0123456789ABCDEF_FEDCBA9876543210;
        resp_mode = 0; resp_st = LLKI_ST_OK;
        beat_q.push_back({2'd0, 1'b0, 64'hFEDCBA9876543210});
        beat_q.push_back({2'd0, 1'b1, 64'h0123456789ABCDEF});
        done_q.push_back(3'd0);
        run_cmd(2'd0, k);
        wait_done(40);
        check("load_latency", 80'(done_cyc - acc_cyc + 1), 80'(5));
        check("ready_low_in_done", 80'(cmd_ready), 80'(0));
        check("beats_left", 80'(beat_q.size()), 80'(0));
        @(posedge clk);
        #1;
        check("ready_after_done", 80'(cmd_ready), 80'(1));

        // LOAD with beat 1 stalled 3 cycles
        k = {$urandom, $urandom, $urandom, $urandom};
        stall_beat = 1; stall_left = 3;
        beat_q.push_back({2'd0, 1'b0, k[63:0]});
        beat_q.push_back({2'd0, 1'b1, k[127:64]});
        done_q.push_back(3'd0);
        run_cmd(2'd0, k);
        wait_done(40);
        check("stall_consumed", 80'(stall_left), 80'(0));
        check("beats_left", 80'(beat_q.size()), 80'(0));
        stall_beat = -1;

        // CLEAR: one beat, data zero even with a key on the port
        beat_q.push_back({2'd1, 1'b1, 64'd0});
        done_q.push_back(3'd0);
        run_cmd(2'd1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
        wait_done(40);
        check("beats_left", 80'(beat_q.size()), 80'(0));

        // STATUS answered with KEY_PRESENT
        resp_st = LLKI_ST_KEY_PRESENT;
        beat_q.push_back({2'd2, 1'b1, 64'd0});
        done_q.push_back(3'd1);
        run_cmd(2'd2, '0);
        wait_done(40);

        // early reject during beat 0 of a LOAD
        resp_mode = 2; resp_st = LLKI_ST_BAD_LEN;
        hs0 = hs_count;
        done_q.push_back(3'd2);
        run_cmd(2'd0, k);
        wait_done(40);
        check("early_no_beats", 80'(hs_count - hs0), 80'(0));
        check("early_req_dropped", 80'(llki_req_valid), 80'(0));
        repeat (3) @(negedge clk);
        check("early_no_beat1", 80'(hs_count - hs0), 80'(0));

        // unknown op goes straight to DONE
        resp_mode = 0; resp_st = LLKI_ST_OK;
        hs0 = hs_count;
        done_q.push_back(3'd3);
        run_cmd(2'd3, k);
        wait_done(40);
        check("badop_latency", 80'(done_cyc - acc_cyc + 1), 80'(2));
        check("badop_no_beats", 80'(hs_count - hs0), 80'(0));

        // reset while waiting for the response
        resp_mode = 1;
        hs0 = done_count;
        beat_q.push_back({2'd1, 1'b1, 64'd0});
        run_cmd(2'd1, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_cmd_ready",   80'(cmd_ready),      80'(1));
        check("mid_rst_req_valid",   80'(llki_req_valid), 80'(0));
        check("mid_rst_req_data",    80'(llki_req_data),  80'(0));
        check("mid_rst_req_last",    80'(llki_req_last),  80'(0));
        check("mid_rst_done_valid",  80'(done_valid),     80'(0));
        check("mid_rst_done_status", 80'(done_status),    80'(0));
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", 80'(done_count - hs0), 80'(0));
        check("beats_left", 80'(beat_q.size()), 80'(0));

`ifdef LLKI_MASTER_TIMEOUT_EN
        // silent slave: watchdog completes the command
        resp_mode = 1;
        beat_q.push_back({2'd1, 1'b1, 64'd0});
        done_q.push_back(3'd4);
        run_cmd(2'd1, '0);
        wait_done(60);
        check("timeout_waited", 80'(done_cyc - acc_cyc > TO), 80'(1));
        resp_mode = 0;
`endif

        check("extra_beats", 80'(extra_beats), 80'(0));
        check("extra_done",  80'(extra_done),  80'(0));
        check("done_q_left", 80'(done_q.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/llki_discrete_master.md
# llki_discrete_master

Initiator end of the LLKI discrete key-load protocol. Takes one key command at a time from the SRoT-side command port and serialises it onto the discrete request/response channel of one LLKI-enabled core's discrete slave. Returns a single completion status per command. One instance per protected core, placed between the SRoT crossbar and that core's LLKI wrapper.

## Interface
- `KEY_WORDS`, default 2: number of 64-bit words in a key (MD5 uses 2, giving a 128-bit key).
- `TIMEOUT_CYCLES`, default 255: maximum number of idle cycles to wait on the slave. Only used when the timeout feature is compiled in.
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: master can accept a command. High only in IDLE.
- `cmd_op` in 2: `LLKI_OP_LOAD`, `LLKI_OP_CLEAR` or `LLKI_OP_STATUS`.
- `cmd_key` in 64*KEY_WORDS: key for a load. Word 0 is `cmd_key[63:0]`.
- `done_valid` out 1: one-cycle completion pulse.
- `done_status` out 3: completion code from `llki_pkg`.
- `llki_req_valid` out 1: request beat valid.
- `llki_req_ready` in 1: slave accepts the beat.
- `llki_req_op` out 2: opcode carried on every beat.
- `llki_req_data` out 64: key word. Zero for clear and status.
- `llki_req_last` out 1: final beat of the command.
- `llki_resp_valid` in 1: slave response, single cycle.
- `llki_resp_status` in 3: slave status code.

## Operation
- States are IDLE, SEND, WAIT_RESP and DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, capture `cmd_op` and `cmd_key`, clear the beat counter `idx`, then go to SEND.
  - An unknown op (value 3) goes straight to DONE with `LLKI_ST_BAD_OP`.
- SEND:
  - Drive `llki_req_valid`=1, `llki_req_op`=captured op, and `llki_req_data`=word `idx`.
  - `llki_req_last` is high when `idx`==KEY_WORDS-1 for a load. Clear and status are a single beat with `last`=1.
  - Hold all request outputs stable until `llki_req_ready`.
  - On a handshake with `last`, go to WAIT_RESP. Otherwise increment `idx`.
- WAIT_RESP: on `llki_resp_valid`, latch `llki_resp_status` and go to DONE.
- DONE:
  - `done_valid`=1 for exactly one cycle with the latched status, then go to IDLE.
- Early response: if `llki_resp_valid` arrives during SEND, abort and go to DONE with the slave's status. This is how the slave rejects a load early.
- Scrubbing: the captured key register is zeroed on entry to DONE and on reset. No key material survives a completed command.
- Reset mid-operation: all state returns to IDLE and the key register is zeroed. No `done_valid` is issued for the aborted command.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `llki_req_valid`=0, `llki_req_op`=0, `llki_req_data`=0, `llki_req_last`=0.
  - `done_valid`=0, `done_status`=0.
- All outputs are registered.
- Command accept to first request beat: 1 cycle.
- Each beat takes at least 1 cycle. The next beat can follow back-to-back when `llki_req_ready` is held high.
- Response to `done_valid`: 1 cycle.
- Minimum LOAD latency with KEY_WORDS=2, slave always ready, and response the cycle after `last`: 5 cycles from `cmd_valid`&`cmd_ready` to `done_valid`.
- `cmd_ready` is low from the accept cycle through the DONE cycle. The next command can be accepted the cycle after DONE.

## Configuration
- `LLKI_MASTER_TIMEOUT_EN` defined:
  - An 8-bit-or-wider down-counter is loaded with TIMEOUT_CYCLES on entry to SEND, on each accepted beat, and on entry to WAIT_RESP.
  - The counter decrements every cycle without progress.
  - At zero, go to DONE with `LLKI_ST_TIMEOUT` and drop `llki_req_valid`.
- Not defined: the master waits indefinitely and no counter is instantiated.

## Structure
- `llki_pkg` holds the following, shared with the discrete slave:
  - `llki_op_e`: LOAD=0, CLEAR=1, STATUS=2.
  - `llki_status_e`: OK=0, KEY_PRESENT=1, BAD_LEN=2, BAD_OP=3, TIMEOUT=4.
  - The 64-bit word width constant.
- Sub-module `llki_timeout_ctr`, instantiated only under `LLKI_MASTER_TIMEOUT_EN`. Its ports are load, load value, tick, and expired.
- The FSM and the key shift register live in the top module.

## Test plan
- LOAD with key 0x0123456789ABCDEF_FEDCBA9876543210 and a slave that is always ready, responding OK:
  - Beat 0 carries data 0xFEDCBA9876543210 with `last`=0.
  - Beat 1 carries 0x0123456789ABCDEF with `last`=1.
  - `done_status`=0, 5 cycles after accept.
- LOAD with `llki_req_ready` low for 3 cycles on beat 1: data and op are held stable throughout, then completion is OK.
- CLEAR: a single beat with op=1, data=0, `last`=1. The slave responds OK, giving `done_status`=0.
- Slave responds BAD_LEN=2 during beat 0 of a LOAD: abort, `done_status`=2, and no beat 1 is sent.
- `rst_n` pulled low in WAIT_RESP: all outputs are at reset values the next cycle, no `done_valid` is issued, and `cmd_ready`=1.
- With `LLKI_MASTER_TIMEOUT_EN` and TIMEOUT_CYCLES=10, on a slave that never responds: `done_status`=4 after 10 idle cycles in WAIT_RESP.
